score_argmax_stream: RTL and testbench

- Streaming argmax over one frame of floating-point confidence scores. Used ahead of NMS to find the highest-scoring candidate box and count candidates above a runtime threshold.
- Successor to the fixed fp16 greater-than compare:
  - parametrised exponent and mantissa widths
  - IEEE-correct signed-zero and NaN handling
  - valid/ready streaming with per-frame result hold

---
 rtl/score_pkg.sv | 53 +++++
 rtl/fp_gt_cmp.sv | 48 ++++
 rtl/score_argmax_stream.sv | 142 ++++++++++++++
 tb/tb_score_argmax_stream.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and helpers for the streaming score argmax block.
// Field helpers take a raw score zero-extended to MAX_SW bits plus the
// exponent/mantissa widths, so any parameterisation can use them.
package score_pkg;

    localparam int unsigned MAX_SW = 64;

    typedef logic [MAX_SW-1:0] raw_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Total score width: sign + exponent + mantissa.
    function automatic int unsigned score_width(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Low-order mask of w ones.
    function automatic raw_t field_mask(input int unsigned w);
        return (raw_t'(1) << w) - raw_t'(1);
    endfunction

    function automatic logic get_sign(input raw_t x, input int unsigned exp_w, input int unsigned man_w);
        raw_t t;
        t = x >> (exp_w + man_w);
        return t[0];
    endfunction

    function automatic raw_t get_exp(input raw_t x, input int unsigned exp_w, input int unsigned man_w);
        return (x >> man_w) & field_mask(exp_w);
    endfunction

    function automatic raw_t get_man(input raw_t x, input int unsigned man_w);
        return x & field_mask(man_w);
    endfunction

    // Exponent and mantissa together: the unsigned magnitude key.
    function automatic raw_t get_mag(input raw_t x, input int unsigned exp_w, input int unsigned man_w);
        return x & field_mask(exp_w + man_w);
    endfunction

    function automatic logic is_nan(input raw_t x, input int unsigned exp_w, input int unsigned man_w);
        return (get_exp(x, exp_w, man_w) == field_mask(exp_w)) && (get_man(x, man_w) != '0);
    endfunction

    function automatic logic is_zero(input raw_t x, input int unsigned exp_w, input int unsigned man_w);
        return get_mag(x, exp_w, man_w) == '0;
    endfunction

endpackage

// File: rtl/fp_gt_cmp.sv
// Combinational floating-point strict greater-than.
// Sign-magnitude order; +0 == -0; any NaN operand yields false; infinities
// and subnormals compare exactly by their bit patterns.
// Ports: i_a, i_b  scores (SW bits); o_a_gt_b_c  1 when i_a > i_b.
module fp_gt_cmp
    import score_pkg::*;
#(
    parameter  int unsigned EXP_W = 5,
    parameter  int unsigned MAN_W = 10,
    localparam int unsigned SW    = score_width(EXP_W, MAN_W)
) (
    input  logic [SW-1:0] i_a,
    input  logic [SW-1:0] i_b,
    output logic          o_a_gt_b_c
);

    raw_t w_a;
    raw_t w_b;
    raw_t w_mag_a;
    raw_t w_mag_b;
    logic w_sign_a;
    logic w_sign_b;
    logic w_any_nan;
    logic w_both_zero;

    assign w_a         = raw_t'(i_a);
    assign w_b         = raw_t'(i_b);
    assign w_mag_a     = get_mag(w_a, EXP_W, MAN_W);
    assign w_mag_b     = get_mag(w_b, EXP_W, MAN_W);
    assign w_sign_a    = get_sign(w_a, EXP_W, MAN_W);
    assign w_sign_b    = get_sign(w_b, EXP_W, MAN_W);
    assign w_any_nan   = is_nan(w_a, EXP_W, MAN_W) || is_nan(w_b, EXP_W, MAN_W);
    assign w_both_zero = is_zero(w_a, EXP_W, MAN_W) && is_zero(w_b, EXP_W, MAN_W);

    // Negative operands order by reversed magnitude.
    always_comb begin
        o_a_gt_b_c = 1'b0;
        if (!w_any_nan && !w_both_zero) begin
            case ({w_sign_a, w_sign_b})
                2'b01:   o_a_gt_b_c = 1'b1;
                2'b00:   o_a_gt_b_c = (w_mag_a > w_mag_b);
                2'b11:   o_a_gt_b_c = (w_mag_a < w_mag_b);
                default: o_a_gt_b_c = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/score_argmax_stream.sv
// Streaming argmax over one frame of floating-point scores.
// Tracks the earliest strictly-largest beat above a per-frame threshold,
// counts qualifying beats (saturating) and flags index overflow; the result
// is held until the consumer takes it.
// Ports: clk/rst (sync, active high); thresh; in_valid/in_ready/in_score/
// in_last beat stream; out_valid/out_ready result handshake; out_found,
// out_score, out_idx, out_count, out_ovf frame result.
module score_argmax_stream
    import score_pkg::*;
#(
    parameter  int unsigned EXP_W = 5,
    parameter  int unsigned MAN_W = 10,
    parameter  int unsigned IDX_W = 12,
    localparam int unsigned SW    = score_width(EXP_W, MAN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW-1:0]    thresh,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SW-1:0]    in_score,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_found,
    output logic [SW-1:0]    out_score,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [SW-1:0]    r_thresh;
    logic [SW-1:0]    r_best;
    logic [IDX_W-1:0] r_best_idx;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_count;
    logic             r_found;
    logic             r_ovf;

    logic             w_accept;
    logic             w_first;
    logic [SW-1:0]    w_thresh_eff;
    logic [IDX_W-1:0] w_idx_cur;
    logic [IDX_W-1:0] w_count_base;
    logic             w_found_base;
    logic             w_ovf_base;
    logic             w_wrap;
    logic             w_qual;
    logic             w_better;
    logic             w_load;

    // Next-state decode; in_ready is only ever a function of state.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = in_valid && r_in_ready;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
            ST_ACCUM: if (w_accept && in_last) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register with handshake flags precomputed from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_HOLD);
            r_out_valid <= (w_state_nxt == ST_HOLD);
        end
    end

    // The first beat of a frame uses the live threshold and fresh accumulators.
    always_comb begin
        w_first      = (r_state == ST_IDLE);
        w_thresh_eff = w_first ? thresh : r_thresh;
        w_idx_cur    = w_first ? '0 : r_idx + IDX_W'(1);
        w_wrap       = !w_first && (r_idx == IDX_MAX);
        w_found_base = !w_first && r_found;
        w_ovf_base   = !w_first && r_ovf;
        w_count_base = w_first ? '0 : r_count;
        w_load       = w_qual && (!w_found_base || w_better);
    end

    fp_gt_cmp #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_thr_cmp (
        .i_a        (in_score),
        .i_b        (w_thresh_eff),
        .o_a_gt_b_c (w_qual)
    );

    fp_gt_cmp #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_best_cmp (
        .i_a        (in_score),
        .i_b        (r_best),
        .o_a_gt_b_c (w_better)
    );

    // Per-beat accumulation; a new frame clears best so unfound reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_thresh   <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_idx      <= '0;
            r_count    <= '0;
            r_found    <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_thresh <= w_thresh_eff;
            r_idx    <= w_idx_cur;
            r_ovf    <= w_ovf_base || w_wrap;
            r_found  <= w_found_base || w_qual;
            r_count  <= (w_qual && (w_count_base != IDX_MAX)) ? w_count_base + IDX_W'(1)
                                                              : w_count_base;
            if (w_load) begin
                r_best     <= in_score;
                r_best_idx <= w_idx_cur;
            end else if (w_first) begin
                r_best     <= '0;
                r_best_idx <= '0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_found = r_found;
    assign out_score = r_best;
    assign out_idx   = r_best_idx;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_score_argmax_stream.sv
// Self-checking bench: two instances (IDX_W=12 and IDX_W=2) share one fp16
// stimulus stream; results are checked against a real-valued frame model.
module tb_score_argmax_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] thresh;
    logic        in_valid;
    logic [15:0] in_score;
    logic        in_last;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_found, a_ovf;
    logic [15:0] a_score;
    logic [11:0] a_idx, a_count;
    logic        b_in_ready, b_out_valid, b_found, b_ovf;
    logic [15:0] b_score;
    logic [1:0]  b_idx, b_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        found;
        logic [15:0] score;
        int          idx;
        int          count;
        logic        ovf;
    } res_t;

    always #5 clk = ~clk;

    score_argmax_stream #(.EXP_W(5), .MAN_W(10), .IDX_W(12)) dut_a (
        .clk(clk), .rst(rst), .thresh(thresh),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_score(in_score), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_found(a_found), .out_score(a_score), .out_idx(a_idx),
        .out_count(a_count), .out_ovf(a_ovf)
    );

    score_argmax_stream #(.EXP_W(5), .MAN_W(10), .IDX_W(2)) dut_b (
        .clk(clk), .rst(rst), .thresh(thresh),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_score(in_score), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_found(b_found), .out_score(b_score), .out_idx(b_idx),
        .out_count(b_count), .out_ovf(b_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // fp16 numeric value; infinities map beyond the finite range.
    function automatic real fp_val(input logic [15:0] x);
        int  e;
        int  m;
        real s;
        real mag;
        e = int'(x[14:10]);
        m = int'(x[9:0]);
        s = 1.0;
        for (int k = 0; k < e; k++) s = s * 2.0;
        if (e == 31)     mag = 1.0e30;
        else if (e == 0) mag = m / 16777216.0;
        else             mag = (1024 + m) * s / 33554432.0;
        return x[15] ? -mag : mag;
    endfunction

    function automatic bit fp_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
    endfunction

    function automatic bit fp_gt(input logic [15:0] a, input logic [15:0] b);
        if (fp_nan(a) || fp_nan(b)) return 1'b0;
        return fp_val(a) > fp_val(b);
    endfunction

    function automatic res_t model(input logic [15:0] thr, input logic [15:0] beats[$], input int idx_w);
        res_t r;
        int   cnt;
        int   span;
        r     = '{found: 1'b0, score: 16'h0, idx: 0, count: 0, ovf: 1'b0};
        cnt   = 0;
        span  = 1 << idx_w;
        for (int i = 0; i < beats.size(); i++) begin
            if (fp_gt(beats[i], thr)) begin
                cnt++;
                if (!r.found || fp_gt(beats[i], r.score)) begin
                    r.found = 1'b1;
                    r.score = beats[i];
                    r.idx   = i % span;
                end
            end
        end
        r.count = (cnt > span - 1) ? span - 1 : cnt;
        r.ovf   = beats.size() > span;
        return r;
    endfunction

    task automatic check_result(input string tag, input res_t ea, input res_t eb);
        check({tag, ".a.found"}, 32'(a_found), 32'(ea.found));
        check({tag, ".a.score"}, 32'(a_score), 32'(ea.score));
        check({tag, ".a.idx"},   32'(a_idx),   32'(ea.idx));
        check({tag, ".a.count"}, 32'(a_count), 32'(ea.count));
        check({tag, ".a.ovf"},   32'(a_ovf),   32'(ea.ovf));
        check({tag, ".b.found"}, 32'(b_found), 32'(eb.found));
        check({tag, ".b.score"}, 32'(b_score), 32'(eb.score));
        check({tag, ".b.idx"},   32'(b_idx),   32'(eb.idx));
        check({tag, ".b.count"}, 32'(b_count), 32'(eb.count));
        check({tag, ".b.ovf"},   32'(b_ovf),   32'(eb.ovf));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".a.in_ready"},  32'(a_in_ready),  32'd1);
        check({tag, ".a.out_valid"}, 32'(a_out_valid), 32'd0);
        check({tag, ".b.in_ready"},  32'(b_in_ready),  32'd1);
        check({tag, ".b.out_valid"}, 32'(b_out_valid), 32'd0);
    endtask

    // Drive beats on falling edges; threshold is scrambled after the first beat.
    task automatic send_beats(input logic [15:0] thr, input logic [15:0] beats[$],
                              input bit with_last, input int gap_max);
        for (int i = 0; i < beats.size(); i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                @(negedge clk);
                in_valid = 1'b0;
                thresh   = 16'($urandom);
            end
            @(negedge clk);
            check("beat.in_ready", 32'(a_in_ready & b_in_ready), 32'd1);
            in_valid = 1'b1;
            in_score = beats[i];
            in_last  = with_last && (i == beats.size() - 1);
            thresh   = (i == 0) ? thr : 16'($urandom);
        end
    endtask

    task automatic run_frame(input string tag, input logic [15:0] thr,
                             input logic [15:0] beats[$], input int gap_max, input int stall);
        res_t ea;
        res_t eb;
        ea = model(thr, beats, 12);
        eb = model(thr, beats, 2);
        send_beats(thr, beats, 1'b1, gap_max);
        @(negedge clk);
        in_valid  = 1'b1;
        in_score  = 16'($urandom);
        in_last   = 1'($urandom);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            check({tag, ".hold.valid"}, 32'(a_out_valid & b_out_valid), 32'd1);
            check({tag, ".hold.in_ready"}, 32'(a_in_ready | b_in_ready), 32'd0);
            check_result({tag, ".hold"}, ea, eb);
            @(negedge clk);
            in_score = 16'($urandom);
        end
        check({tag, ".valid"}, 32'(a_out_valid & b_out_valid), 32'd1);
        check({tag, ".in_ready"}, 32'(a_in_ready | b_in_ready), 32'd0);
        check_result(tag, ea, eb);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_idle({tag, ".after"});
    endtask

    function automatic logic [15:0] rand_score();
        case ($urandom_range(7, 0))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return $urandom_range(1, 0) ? 16'h7C00 : 16'hFC00;
            3:       return {1'($urandom), 5'h1F, 10'($urandom) | 10'h1};
            4:       return {1'($urandom), 5'h00, 10'($urandom)};
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] q[$];
        res_t        zero_r;
        zero_r    = '{found: 1'b0, score: 16'h0, idx: 0, count: 0, ovf: 1'b0};
        rst       = 1'b1;
        thresh    = 16'h0;
        in_valid  = 1'b0;
        in_score  = 16'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        check_result("reset", zero_r, zero_r);

        q = '{16'h3C00, 16'h4000, 16'h3A00, 16'h4000};
        run_frame("tie", 16'h3800, q, 0, 0);
        q = '{16'h0000, 16'h8000};
        run_frame("szero", 16'h8000, q, 0, 0);
        q = '{16'h7E00, 16'hC000, 16'hB800};
        run_frame("negnan", 16'hBC00, q, 1, 0);
        q = '{16'h3C00, 16'h4000};
        run_frame("bp", 16'h0000, q, 0, 5);
        q = '{16'h3C00, 16'h3E00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
        run_frame("ovf", 16'h0000, q, 0, 1);
        q = '{16'h3C00};
        run_frame("nanthr", 16'h7C01, q, 0, 0);

        // Reset mid-frame discards the partial frame.
        q = '{16'h4800, 16'h4900};
        send_beats(16'h0000, q, 1'b0, 0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_idle("midrst");
        check_result("midrst", zero_r, zero_r);
        q = '{16'h3C00};
        run_frame("postrst", 16'h0000, q, 0, 0);

        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(8, 1);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(rand_score());
            run_frame($sformatf("rnd%0d", f), rand_score(), q, 2, $urandom_range(3, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
